// File: rtl/gpr_wb_sched.sv
// rtl/gpr_wb_sched.sv - GPR write-port scheduler: pipeline write-back vs queued long-latency results
module gpr_wb_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8,
    parameter int REG_NUM    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_we_,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_req,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ack,
    input  logic        rsv_valid,
    input  logic [4:0]  rsv_addr,
    output logic        rsv_busy,
    input  logic [4:0]  rd_addr_0,
    output logic        rd_busy_0,
    input  logic [4:0]  rd_addr_1,
    output logic        rd_busy_1,
    output logic        wb_stall,
    output logic        gpr_we_,
    output logic [4:0]  gpr_wr_addr,
    output logic [31:0] gpr_wr_data,
    output logic        sched_idle
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam logic [PW:0]   FULL_CNT    = (PW+1)'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

    logic [4:0]          fifo_addr [FIFO_DEPTH];
    logic [31:0]         fifo_data [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [PW:0]         count;
    logic [REG_NUM-1:0]  busy;
    logic [REG_NUM-1:0]  set_mask;
    logic [REG_NUM-1:0]  clr_mask;
    logic [SW-1:0]       starve_cnt;

    logic fifo_empty;
    logic fifo_full;
    logic a_sel;
    logic push;
    logic pop;
    logic hold;
    logic [4:0]  head_addr;
    logic [31:0] head_data;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign a_sel      = !a_we_;
    assign b_ack      = !fifo_full;
    assign push       = b_req && !fifo_full;
    // Queued results are discarded by reset, so the head never reaches the port during reset
    assign pop        = !reset && a_we_ && !fifo_empty;
    // A owns the port while a result is waiting: the starvation condition
    assign hold       = a_sel && !fifo_empty;
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];

    assign rsv_busy   = busy[rsv_addr];
    assign rd_busy_0  = busy[rd_addr_0];
    assign rd_busy_1  = busy[rd_addr_1];
    assign sched_idle = fifo_empty && (busy == '0);

    // Write-port mux: pipeline first, then the FIFO head, else idle with zeroed address/data
    always_comb begin
        gpr_we_     = 1'b1;
        gpr_wr_addr = 5'd0;
        gpr_wr_data = 32'd0;
        if (a_sel) begin
            gpr_we_     = 1'b0;
            gpr_wr_addr = a_addr;
            gpr_wr_data = a_data;
        end else if (pop) begin
            gpr_we_     = 1'b0;
            gpr_wr_addr = head_addr;
            gpr_wr_data = head_data;
        end
    end

    // Result storage; contents are don't-care outside the valid window, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= b_addr;
            fifo_data[wr_ptr] <= b_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since the depth is a power of 2
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Scoreboard set/clear masks for this cycle
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (rsv_valid) set_mask[rsv_addr]  = 1'b1;
        if (pop)       clr_mask[head_addr] = 1'b1;
    end

    // Scoreboard update; a new reservation wins over a retiring result to the same register
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    // Starvation counter and single-cycle wb_stall pulse that forces one drain slot
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            wb_stall   <= 1'b0;
        end else begin
            if (fifo_empty || pop) begin
                starve_cnt <= '0;
            end else if (hold && (starve_cnt != STARVE_LAST)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            wb_stall <= hold && (starve_cnt == STARVE_LAST);
        end
    end

endmodule

// File: tb/tb_gpr_wb_sched.sv
// tb/tb_gpr_wb_sched.sv - directed vector and sequence bench for gpr_wb_sched
module tb_gpr_wb_sched;

    logic        clk;
    logic        reset;
    logic        a_we_;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_req;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ack;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        rsv_busy;
    logic [4:0]  rd_addr_0;
    logic        rd_busy_0;
    logic [4:0]  rd_addr_1;
    logic        rd_busy_1;
    logic        wb_stall;
    logic        gpr_we_;
    logic [4:0]  gpr_wr_addr;
    logic [31:0] gpr_wr_data;
    logic        sched_idle;

    int errors = 0;
    int checks = 0;

    gpr_wb_sched #(.FIFO_DEPTH(4), .STARVE_MAX(8), .REG_NUM(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .a_we_       (a_we_),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .b_req       (b_req),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .b_ack       (b_ack),
        .rsv_valid   (rsv_valid),
        .rsv_addr    (rsv_addr),
        .rsv_busy    (rsv_busy),
        .rd_addr_0   (rd_addr_0),
        .rd_busy_0   (rd_busy_0),
        .rd_addr_1   (rd_addr_1),
        .rd_busy_1   (rd_busy_1),
        .wb_stall    (wb_stall),
        .gpr_we_     (gpr_we_),
        .gpr_wr_addr (gpr_wr_addr),
        .gpr_wr_data (gpr_wr_data),
        .sched_idle  (sched_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        a_we_;
        logic [4:0]  a_addr;
        logic [31:0] a_data;
        logic        b_req;
        logic [4:0]  b_addr;
        logic [31:0] b_data;
        logic        rsv_valid;
        logic [4:0]  rsv_addr;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic        e_we_;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_ack;
        logic        e_busy0;
        logic        e_busy1;
        logic        e_rsvb;
        logic        e_idle;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Decode never issues a reservation onto a register that is still busy
    always @(negedge clk) begin
        if (!reset && rsv_valid) begin
            checks++;
            if (rsv_busy !== 1'b0) begin
                errors++;
                $display("FAIL rsv_protocol: rsv_busy=%b for r%0d expected 0", rsv_busy, rsv_addr);
            end
        end
    end

    task automatic idle_inputs();
        a_we_ = 1'b1; a_addr = '0; a_data = '0;
        b_req = 1'b0; b_addr = '0; b_data = '0;
        rsv_valid = 1'b0; rsv_addr = '0;
        rd_addr_0 = '0; rd_addr_1 = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic chk_port(input string tag, input logic we, input logic [4:0] ad, input logic [31:0] da);
        chk({tag, "_we_"}, 32'(gpr_we_), 32'(we));
        chk({tag, "_addr"}, 32'(gpr_wr_addr), 32'(ad));
        chk({tag, "_data"}, gpr_wr_data, da);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #1;
        do_reset();

        vecs[0] = '{1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd31,
                    1'b1, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd0,
                    1'b1, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd5, 5'd0,
                    1'b1, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd5, 5'd5,
                    1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd5, 5'd0,
                    1'b1, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd3, 5'd7,
                    1'b0, 5'd3, 32'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0,
                    1'b0, 5'd7, 32'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 5'd1, 32'hAAAA0001, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd1, 5'd9,
                    1'b0, 5'd1, 32'hAAAA0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd9, 5'd1,
                    1'b1, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        // Table: one record per cycle, outputs observed before the closing edge
        for (int i = 0; i < 9; i++) begin
            a_we_ = vecs[i].a_we_; a_addr = vecs[i].a_addr; a_data = vecs[i].a_data;
            b_req = vecs[i].b_req; b_addr = vecs[i].b_addr; b_data = vecs[i].b_data;
            rsv_valid = vecs[i].rsv_valid; rsv_addr = vecs[i].rsv_addr;
            rd_addr_0 = vecs[i].rd0; rd_addr_1 = vecs[i].rd1;
            @(negedge clk);
            chk_port($sformatf("v%0d", i), vecs[i].e_we_, vecs[i].e_addr, vecs[i].e_data);
            chk($sformatf("v%0d_b_ack", i), 32'(b_ack), 32'(vecs[i].e_ack));
            chk($sformatf("v%0d_rd_busy_0", i), 32'(rd_busy_0), 32'(vecs[i].e_busy0));
            chk($sformatf("v%0d_rd_busy_1", i), 32'(rd_busy_1), 32'(vecs[i].e_busy1));
            chk($sformatf("v%0d_rsv_busy", i), 32'(rsv_busy), 32'(vecs[i].e_rsvb));
            chk($sformatf("v%0d_sched_idle", i), 32'(sched_idle), 32'(vecs[i].e_idle));
            chk($sformatf("v%0d_wb_stall", i), 32'(wb_stall), 32'h0);
            next_cycle();
        end

        // Starvation: A writes r3 every cycle, r7 and r8 queued behind it
        do_reset();
        for (int cyc = 0; cyc < 20; cyc++) begin
            logic exp_stall;
            exp_stall = (cyc == 9) || (cyc == 18);
            a_we_  = wb_stall;
            a_addr = 5'd3;
            a_data = 32'h11;
            b_req  = (cyc < 2);
            b_addr = (cyc == 0) ? 5'd7 : 5'd8;
            b_data = (cyc == 0) ? 32'h22 : 32'h33;
            @(negedge clk);
            chk($sformatf("starve_c%0d_wb_stall", cyc), 32'(wb_stall), 32'(exp_stall));
            if (cyc == 9) chk_port("starve_c9", 1'b0, 5'd7, 32'h22);
            else if (cyc == 18) chk_port("starve_c18", 1'b0, 5'd8, 32'h33);
            else chk_port($sformatf("starve_c%0d", cyc), 1'b0, 5'd3, 32'h11);
            next_cycle();
        end
        b_req = 1'b0;
        @(negedge clk);
        chk("starve_end_idle", 32'(sched_idle), 32'h1);
        next_cycle();

        // Full FIFO back-pressure, no push-while-full on a pop cycle, drain order
        do_reset();
        for (int cyc = 0; cyc <= 10; cyc++) begin
            a_we_  = (cyc >= 5);
            a_addr = 5'd3;
            a_data = 32'h11;
            b_req  = (cyc <= 6);
            b_addr = (cyc < 4) ? 5'(10 + cyc) : 5'd14;
            b_data = 32'h100 + 32'(b_addr);
            @(negedge clk);
            chk($sformatf("full_c%0d_b_ack", cyc), 32'(b_ack), 32'(!(cyc == 4 || cyc == 5)));
            if (cyc < 5) chk_port($sformatf("full_c%0d", cyc), 1'b0, 5'd3, 32'h11);
            else if (cyc < 10) chk_port($sformatf("full_c%0d", cyc), 1'b0, 5'(cyc + 5), 32'h100 + 32'(cyc + 5));
            else chk_port("full_c10", 1'b1, 5'd0, 32'h0);
            next_cycle();
        end
        @(negedge clk);
        chk("full_end_idle", 32'(sched_idle), 32'h1);
        next_cycle();

        // Reservation and retirement of r9 in the same cycle: reservation wins
        do_reset();
        b_req = 1'b1; b_addr = 5'd9; b_data = 32'h99;
        @(negedge clk);
        chk_port("setwin_c0", 1'b1, 5'd0, 32'h0);
        next_cycle();
        idle_inputs();
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        @(negedge clk);
        chk_port("setwin_c1", 1'b0, 5'd9, 32'h99);
        next_cycle();
        idle_inputs();
        rd_addr_0 = 5'd9;
        @(negedge clk);
        chk("setwin_rd_busy_0", 32'(rd_busy_0), 32'h1);
        chk("setwin_idle", 32'(sched_idle), 32'h0);
        next_cycle();

        // Reset with three queued results and r2/r4 reserved
        do_reset();
        for (int cyc = 0; cyc < 3; cyc++) begin
            a_we_ = 1'b0; a_addr = 5'd3; a_data = 32'h11;
            b_req = 1'b1; b_addr = 5'(20 + cyc); b_data = 32'hC0 + 32'(cyc);
            rsv_valid = (cyc < 2); rsv_addr = (cyc == 0) ? 5'd2 : 5'd4;
            next_cycle();
        end
        idle_inputs();
        rd_addr_0 = 5'd2; rd_addr_1 = 5'd4;
        @(negedge clk);
        chk("pre_reset_busy_2", 32'(rd_busy_0), 32'h1);
        chk("pre_reset_busy_4", 32'(rd_busy_1), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk_port("reset_cycle", 1'b1, 5'd0, 32'h0);
        next_cycle();
        reset = 1'b0;
        for (int cyc = 0; cyc < 2; cyc++) begin
            @(negedge clk);
            chk_port($sformatf("post_reset_c%0d", cyc), 1'b1, 5'd0, 32'h0);
            chk($sformatf("post_reset_c%0d_idle", cyc), 32'(sched_idle), 32'h1);
            chk($sformatf("post_reset_c%0d_b_ack", cyc), 32'(b_ack), 32'h1);
            chk($sformatf("post_reset_c%0d_busy_2", cyc), 32'(rd_busy_0), 32'h0);
            chk($sformatf("post_reset_c%0d_busy_4", cyc), 32'(rd_busy_1), 32'h0);
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpr_wb_sched.md
Name: gpr_wb_sched

Overview:
- Write-back scheduler for the single GPR write port. It shares that port between the in-order pipeline write-back (requester A) and a long-latency unit such as mul/div (requester B).
- B results are queued in a small FIFO and drained whenever A leaves the port idle.
- A per-register scoreboard tracks destinations reserved by B, so the decode stage can stall on pending operands.
- Sits between the pipeline/long-latency unit and gpr; its outputs drive gpr's we_/wr_addr/wr_data directly.

Parameters:
FIFO_DEPTH, 4, B result queue entries (power of 2, >=2)
STARVE_MAX, 8, consecutive cycles a FIFO head may wait before wb_stall is raised
REG_NUM, 32, number of GPRs / scoreboard bits

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
a_we_  in  1  pipeline write-back enable, active-low
a_addr  in  5  pipeline destination register
a_data  in  32  pipeline write data
b_req  in  1  long-latency unit result valid
b_addr  in  5  result destination register
b_data  in  32  result data
b_ack  out  1  result accepted this cycle (b_req & b_ack = transfer)
rsv_valid  in  1  reserve rsv_addr at issue of a long-latency op
rsv_addr  in  5  register to reserve
rsv_busy  out  1  busy[rsv_addr], combinational
rd_addr_0  in  5  decode operand 0 address
rd_busy_0  out  1  busy[rd_addr_0], combinational
rd_addr_1  in  5  decode operand 1 address
rd_busy_1  out  1  busy[rd_addr_1], combinational
wb_stall  out  1  registered; pipeline must hold a_we_ disabled while set
gpr_we_  out  1  to gpr we_, active-low
gpr_wr_addr  out  5  to gpr wr_addr
gpr_wr_data  out  32  to gpr wr_data
sched_idle  out  1  FIFO empty and no busy bits set

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port reset. All state updates on posedge clk.
- Reset values: FIFO empty, busy all 0, starve counter 0, wb_stall=0. With a_we_ disabled this gives gpr_we_=1, gpr_wr_addr=0, gpr_wr_data=0, b_ack=1, sched_idle=1.
- Reset mid-operation: queued B results are discarded and all reservations are cleared. The unit is reset alongside, so no stale result may arrive.
- Port mux (combinational, zero latency):
  - a_we_ enabled: port = A.
  - else if FIFO non-empty: port = FIFO head, and the head is popped at the clock edge.
  - else: gpr_we_=1, addr/data = 0.
  - A always has priority in the same cycle; A is never back-pressured.
- B intake:
  - b_ack = !full. There is no push-while-full, even if a pop occurs that cycle.
  - A transfer pushes {b_addr, b_data}.
  - Earliest GPR write of an accepted result is the next cycle.
  - Simultaneous push and pop when not full is allowed; the count is unchanged.
  - Push to an empty FIFO is never bypassed to the port in the same cycle.
- FIFO order: strict FIFO; pointers wrap modulo FIFO_DEPTH.
- Scoreboard:
  - Set busy[rsv_addr] on rsv_valid.
  - Clear busy[x] on the cycle the FIFO head with addr x is written to GPR.
  - Set and clear of the same register in the same cycle: set wins.
  - rsv_valid while rsv_busy=1 is a protocol violation; decode stalls on rsv_busy. The bench flags it.
  - A writes never touch busy bits.
  - Read hazard: rd_busy_n is pure lookup. Once a bit clears, the gpr write-after-read bypass supplies the value that same cycle.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and A holds the port. It resets to 0 on any pop or when the FIFO is empty.
  - When counter == STARVE_MAX-1 and A holds the port, wb_stall is set on the next edge.
  - While wb_stall=1 the head drains (A is guaranteed idle). wb_stall clears on the edge after that pop.
  - wb_stall lasts exactly 1 cycle per trigger.
- sched_idle: combinational, (count==0) && (busy==0).

Test Plan:
- Reset, then idle → gpr_we_=1, b_ack=1, sched_idle=1, rd_busy_0/1=0 for all addresses.
- rsv r5; B returns r5=0xDEADBEEF at cycle N with a_we_ high → gpr write r5 at N+1, busy[5] clears at N+1, rd_busy_0(r5)=0 from N+2.
- A writes r3=0x11 continuously while B pushes r7=0x22 and r8=0x33 → port always carries A. After STARVE_MAX cycles wb_stall=1 for 1 cycle. r7 is written in the stall cycle, r8 after the next trigger or when A is idle.
- Fill FIFO with 4 results while A is busy → b_ack=0 on the 5th; one pop → b_ack=1 the next cycle. Drain order matches push order.
- rsv r9 and FIFO head r9 retiring in the same cycle → busy[9] stays 1.
- Assert reset with 3 queued entries and busy[2,4]=1 → next cycle: FIFO empty, busy all 0, no GPR write of discarded data, sched_idle=1.
